// File: rtl/rr_arbiter2x1_if.sv
// Handshake bundle for the two-source round-robin arbiter: sources A/B, output Y, mux select.
// The per-source accept counters exist only when RR_CNT_EN is defined.
interface rr_arbiter2x1_if #(
    parameter int unsigned WIDTH = 8
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             sel;
    logic             y_valid;
    logic [WIDTH-1:0] y_data;
    logic             y_ready;
`ifdef RR_CNT_EN
    logic [7:0]       cnt_a;
    logic [7:0]       cnt_b;
`endif

    // Arbiter side
    modport slave (
        input  a_valid, a_data, b_valid, b_data, y_ready,
        output a_ready, b_ready, sel, y_valid, y_data
`ifdef RR_CNT_EN
        , output cnt_a, cnt_b
`endif
    );

    // Environment side: drives sources and the output sink
    modport master (
        output a_valid, a_data, b_valid, b_data, y_ready,
        input  a_ready, b_ready, sel, y_valid, y_data
`ifdef RR_CNT_EN
        , input cnt_a, cnt_b
`endif
    );
endinterface

// File: rtl/rr_arbiter2x1.sv
// Two-source round-robin arbiter with a single registered output word and mux select.
// Optional per-source saturating accept counters are built when RR_CNT_EN is defined.
module rr_arbiter2x1 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_arbiter2x1_if.slave bus
);
    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StFullA = 2'd1;
    localparam logic [1:0] StFullB = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sel_q, sel_d;
    logic             ptr_q, ptr_d;   // 0: A wins a tie, 1: B wins a tie
    logic             init_q;         // low for the first cycle after reset release

    logic y_valid;
    logic load_ok;
    logic grant_a;
    logic grant_b;
    logic acc_a;
    logic acc_b;

    always_comb begin
        y_valid = (state_q == StFullA) || (state_q == StFullB);
        load_ok = (state_q == StEmpty) || (y_valid && bus.y_ready);
        grant_a = bus.a_valid && (!bus.b_valid || !ptr_q);
        grant_b = bus.b_valid && (!bus.a_valid || ptr_q);
        // Gating with init_q keeps the reset-release cycle transfer-free
        acc_a   = init_q && load_ok && grant_a;
        acc_b   = init_q && load_ok && grant_b;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (acc_a) begin
            state_d = StFullA;
            data_d  = bus.a_data;
            sel_d   = 1'b1;
            ptr_d   = 1'b1;
        end else if (acc_b) begin
            state_d = StFullB;
            data_d  = bus.b_data;
            sel_d   = 1'b0;
            ptr_d   = 1'b0;
        end else if (y_valid && bus.y_ready) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            data_q  <= '0;
            sel_q   <= 1'b0;
            ptr_q   <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            init_q  <= 1'b1;
        end
    end

    assign bus.a_ready = acc_a;
    assign bus.b_ready = acc_b;
    assign bus.y_valid = y_valid;
    assign bus.y_data  = data_q;
    assign bus.sel     = sel_q;

`ifdef RR_CNT_EN
    logic [7:0] cnt_a_q;
    logic [7:0] cnt_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q <= 8'd0;
            cnt_b_q <= 8'd0;
        end else begin
            if (acc_a && (cnt_a_q != 8'hFF)) cnt_a_q <= cnt_a_q + 8'd1;
            if (acc_b && (cnt_b_q != 8'hFF)) cnt_b_q <= cnt_b_q + 8'd1;
        end
    end

    assign bus.cnt_a = cnt_a_q;
    assign bus.cnt_b = cnt_b_q;
`endif
endmodule

// File: tb/tb_rr_arbiter2x1.sv
// Self-checking bench for rr_arbiter2x1: a reference model pushes accepted words to a scoreboard
// queue and the held output is compared against its head; counters checked when RR_CNT_EN is set.
module tb_rr_arbiter2x1;
    typedef struct packed {
        logic       sel;
        logic [7:0] data;
    } word_t;

    logic clk;
    logic rst_n;

    rr_arbiter2x1_if #(.WIDTH(8)) bus ();

    rr_arbiter2x1 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model state
    word_t      sb[$];
    logic       m_ptr;
    logic       m_init;
    logic [7:0] m_last_data;
    logic       m_last_sel;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // One clock cycle: drive at negedge, check mid-cycle, advance the model at posedge
    task automatic cycle(input logic av, input logic [7:0] ad, input logic bv, input logic [7:0] bd,
                         input logic yr);
        logic  full, ok, ga, gb, ea, eb;
        word_t w;
        @(negedge clk);
        bus.a_valid = av;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_data  = bd;
        bus.y_ready = yr;
        #1;
        full = (sb.size() != 0);
        ok   = !full || yr;
        ga   = av && (!bv || !m_ptr);
        gb   = bv && (!av || m_ptr);
        ea   = m_init && ok && ga;
        eb   = m_init && ok && gb;
        chk("a_ready", {31'd0, bus.a_ready}, {31'd0, ea});
        chk("b_ready", {31'd0, bus.b_ready}, {31'd0, eb});
        chk("y_valid", {31'd0, bus.y_valid}, {31'd0, full});
        if (full) begin
            chk("y_data", {24'd0, bus.y_data}, {24'd0, sb[0].data});
            chk("sel", {31'd0, bus.sel}, {31'd0, sb[0].sel});
        end else begin
            chk("idle y_data", {24'd0, bus.y_data}, {24'd0, m_last_data});
            chk("idle sel", {31'd0, bus.sel}, {31'd0, m_last_sel});
        end
        @(posedge clk);
        if (full && yr) void'(sb.pop_front());
        if (ea || eb) begin
            w.sel  = ea;
            w.data = ea ? ad : bd;
            sb.push_back(w);
            m_ptr       = ea;
            m_last_data = w.data;
            m_last_sel  = w.sel;
        end
        m_init = 1'b1;
    endtask

    // Asynchronous reset pulse between edges with both sources requesting throughout
    task automatic do_reset();
        @(negedge clk);
        bus.a_valid = 1'b1;
        bus.a_data  = 8'hA5;
        bus.b_valid = 1'b1;
        bus.b_data  = 8'h5A;
        bus.y_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst y_valid", {31'd0, bus.y_valid}, 32'd0);
        chk("rst y_data", {24'd0, bus.y_data}, 32'd0);
        chk("rst sel", {31'd0, bus.sel}, 32'd0);
        chk("rst a_ready", {31'd0, bus.a_ready}, 32'd0);
`ifdef RR_CNT_EN
        chk("rst cnt_a", {24'd0, bus.cnt_a}, 32'd0);
        chk("rst cnt_b", {24'd0, bus.cnt_b}, 32'd0);
`endif
        #1 rst_n = 1'b1;
        #1;
        chk("release a_ready", {31'd0, bus.a_ready}, 32'd0);
        chk("release b_ready", {31'd0, bus.b_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("release y_valid", {31'd0, bus.y_valid}, 32'd0);
        sb.delete();
        m_ptr       = 1'b0;
        m_init      = 1'b1;
        m_last_data = 8'h00;
        m_last_sel  = 1'b0;
    endtask

    logic [7:0] exp27 [4];

    initial begin
        rst_n       = 1'b0;
        bus.a_valid = 1'b0;
        bus.a_data  = 8'h00;
        bus.b_valid = 1'b0;
        bus.b_data  = 8'h00;
        bus.y_ready = 1'b0;
        m_ptr       = 1'b0;
        m_init      = 1'b0;
        m_last_data = 8'h00;
        m_last_sel  = 1'b0;
        exp27[0] = 8'h11;
        exp27[1] = 8'h22;
        exp27[2] = 8'h11;
        exp27[3] = 8'h22;

        do_reset();

        // Single A word, one-cycle latency
        cycle(1'b1, 8'h3C, 1'b0, 8'h00, 1'b1);
        #1;
        chk("t26 y_valid", {31'd0, bus.y_valid}, 32'd1);
        chk("t26 y_data", {24'd0, bus.y_data}, 32'h3C);
        chk("t26 sel", {31'd0, bus.sel}, 32'd1);
        cycle(1'b0, 8'hFF, 1'b0, 8'hEE, 1'b1);

        // Alternation with both sources always valid
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
            #1;
            chk("t27 y_data", {24'd0, bus.y_data}, {24'd0, exp27[i]});
            chk("t27 sel", {31'd0, bus.sel}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Backpressure: word held stable, readies low, then reload on the draining edge
        cycle(1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'h66, 1'b1, 8'h77, 1'b0);
            chk("t28 hold a_ready", {31'd0, bus.a_ready}, 32'd0);
            chk("t28 hold b_ready", {31'd0, bus.b_ready}, 32'd0);
            #1;
            chk("t28 hold y_data", {24'd0, bus.y_data}, 32'h55);
        end
        cycle(1'b1, 8'h66, 1'b1, 8'h77, 1'b1);
        #1;
        chk("t28 reload y_valid", {31'd0, bus.y_valid}, 32'd1);
        chk("t28 reload y_data", {24'd0, bus.y_data}, 32'h77);
        chk("t28 reload sel", {31'd0, bus.sel}, 32'd0);

        // Reset while FULL_A, then A must win the first tie
        cycle(1'b1, 8'h99, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        do_reset();
        cycle(1'b1, 8'h12, 1'b1, 8'h34, 1'b1);
        #1;
        chk("t29 first grant data", {24'd0, bus.y_data}, 32'h12);
        chk("t29 first grant sel", {31'd0, bus.sel}, 32'd1);

        // Random traffic, including invalid sources carrying junk data
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
                  ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 2; i++) cycle(1'b0, 8'hAA, 1'b0, 8'hBB, 1'b1);

`ifdef RR_CNT_EN
        do_reset();
        for (int i = 0; i < 300; i++) cycle(1'b1, 8'(i), 1'b0, 8'h00, 1'b1);
        #1;
        chk("cnt_a saturate", {24'd0, bus.cnt_a}, 32'd255);
        chk("cnt_b idle", {24'd0, bus.cnt_b}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rr_arbiter2x1.md
RR_ARBITER2X1 -- requirements
Module: rr_arbiter2x1

Interface
REQ-001 Parameter: WIDTH, default 8, data width of both sources and the output.
REQ-002 Port: clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: a_valid / a_data / a_ready  in / in / out  1 / WIDTH / 1  source A handshake and word.
REQ-005 Port: b_valid / b_data / b_ready  in / in / out  1 / WIDTH / 1  source B handshake and word.
REQ-006 Port: sel  output  1  registered select for the downstream 2:1 mux; 1 = held word came from A, 0 = from B.
REQ-007 Port: y_valid / y_data / y_ready  out / out / in  1 / WIDTH / 1  output handshake and held word.
REQ-008 Port (RR_CNT_EN only): cnt_a, cnt_b  output  8 each  accepted-transfer counts per source.

Function
REQ-009 Transfer on any interface SHALL occur on a rising clk edge where valid and ready are both 1.
REQ-010 Block SHALL hold one output word in a register; states EMPTY, FULL_A, FULL_B.
REQ-011 load_ok SHALL be 1 when state is EMPTY or (y_valid and y_ready); combinational path y_ready -> a_ready/b_ready is permitted.
REQ-012 Grant: only A valid -> A; only B valid -> B; both valid -> source opposite to last granted (pointer); neither -> none.
REQ-013 a_ready SHALL equal load_ok and grant A; b_ready SHALL equal load_ok and grant B; never both 1 in one cycle.
REQ-014 On A accept: y_data <= a_data, sel <= 1, state FULL_A, pointer <= B; on B accept: y_data <= b_data, sel <= 0, state FULL_B, pointer <= A.
REQ-015 y_valid SHALL be 1 exactly in FULL_A or FULL_B.
REQ-016 Drain with no new accept SHALL move to EMPTY; y_data and sel SHALL keep last values in EMPTY.
REQ-017 Simultaneous drain and accept SHALL load the new word with no bubble: sustained throughput 1 word/cycle.
REQ-018 Latency: word accepted at edge N SHALL appear on y_data with y_valid=1 after edge N (one cycle).
REQ-019 While y_valid=1 and y_ready=0, y_data, sel and state SHALL remain stable and both source readies SHALL be 0.
REQ-020 Inputs presented with valid=0 SHALL never be loaded, whatever the data value.

Reset
REQ-021 rst_n=0 SHALL immediately, without clk, force state EMPTY, y_valid 0, y_data 0, sel 0, pointer A, counters 0.
REQ-022 Reset mid-operation SHALL discard the held word; no transfer SHALL complete in the cycle of reset release.
REQ-023 After release, first edge with both sources valid SHALL grant A.

Configuration
REQ-024 Macro RR_CNT_EN defined: cnt_a/cnt_b present, each incremented on every accept of its source, saturating at 255.
REQ-025 Macro RR_CNT_EN undefined: counter ports and logic absent; all other behaviour identical.

Verification
REQ-026 Reset, then a_valid=1 a_data=0x3C, y_ready=1 -> next cycle y_valid=1, y_data=0x3C, sel=1.
REQ-027 Both valid for 4 cycles (A=0x11, B=0x22), y_ready=1 -> y_data sequence 0x11,0x22,0x11,0x22; sel 1,0,1,0.
REQ-028 Word 0x55 held, y_ready=0 for 3 cycles, both sources valid -> y_data stays 0x55, a_ready=b_ready=0; y_ready=1 -> next word loaded same edge.
REQ-029 rst_n pulsed low between edges while FULL_A -> y_valid 0, sel 0 immediately; after release both valid -> A granted first.
REQ-030 RR_CNT_EN: 300 accepts from A only -> cnt_a=255, cnt_b=0; build without macro compiles and passes REQ-026..029.
